// File: rtl/pipe_fetch_skid.sv
// Fetch->decode pipeline register with a 2-entry skid buffer.
// The main register drives the decode-side outputs. The skid register holds
// a second, younger entry while decode stalls. ready_f is decoded from the
// registered occupancy state only, so no combinational path runs from
// ready_d back to fetch.
module pipe_fetch_skid #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_plus_4_f,
    input  logic            valid_f,
    output logic            ready_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus_4_d,
    output logic            valid_d,
    input  logic            ready_d,
    input  logic            flush_d
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // What the main register loads on the next edge when there is no flush.
    typedef enum logic [1:0] {
        MAIN_HOLD = 2'd0,
        MAIN_IN   = 2'd1,
        MAIN_SKID = 2'd2,
        MAIN_NOP  = 2'd3
    } main_sel_t;

    state_t          state, state_next;
    main_sel_t       main_sel;
    logic            skid_load;
    logic            in_fire, out_fire;

    logic [31:0]     main_instr, skid_instr;
    logic [XLEN-1:0] main_pc, skid_pc;
    logic [XLEN-1:0] main_pc4, skid_pc4;

    assign ready_f     = (state != FULL);
    assign valid_d     = (state != EMPTY);
    assign in_fire     = valid_f & ready_f;
    assign out_fire    = valid_d & ready_d;

    assign instr_d     = main_instr;
    assign pc_d        = main_pc;
    assign pc_plus_4_d = main_pc4;

    // Occupancy state register: reset and flush both empty the stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the edge.
        if (reset || flush_d) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and data-path load selects from the handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first. That keeps
        // each path fully assigned, so no latch is inferred.
        state_next = state;
        main_sel   = MAIN_HOLD;
        skid_load  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                    main_sel   = MAIN_IN;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_sel   = MAIN_IN;
                end else if (in_fire) begin
                    state_next = FULL;
                    skid_load  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                    main_sel   = MAIN_NOP;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next = ONE;
                    main_sel   = MAIN_SKID;
                end
            end
            default: begin
                state_next = EMPTY;
                main_sel   = MAIN_NOP;
            end
        endcase
    end

    // Main register: the entry presented to decode.
    // When the stage drains, it shows a NOP and keeps the last pc values.
    always_ff @(posedge clk) begin
        if (reset || flush_d) begin
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
            main_pc4   <= '0;
        end else begin
            unique case (main_sel)
                MAIN_IN: begin
                    main_instr <= instr_f;
                    main_pc    <= pc_f;
                    main_pc4   <= pc_plus_4_f;
                end
                MAIN_SKID: begin
                    main_instr <= skid_instr;
                    main_pc    <= skid_pc;
                    main_pc4   <= skid_pc4;
                end
                MAIN_NOP: begin
                    main_instr <= NOP_INSTR;
                end
                default: begin
                end
            endcase
        end
    end

    // Skid register: holds the younger entry while decode stalls.
    always_ff @(posedge clk) begin
        // NOTE: this storage is normally left unreset. Here it is cleared so
        // the skid never holds X, even though it is only read in FULL.
        if (reset || flush_d) begin
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_pc4   <= '0;
        end else if (skid_load) begin
            skid_instr <= instr_f;
            skid_pc    <= pc_f;
            skid_pc4   <= pc_plus_4_f;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_skid.sv
// Self-checking bench for pipe_fetch_skid.
// The driver applies directed phases and then a random phase.
// A negedge monitor keeps an occupancy model plus an expected-entry queue.
// It compares the handshake signals and the presented entry on every cycle.
module tb_pipe_fetch_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr_f, pc_f, pc_plus_4_f;
    logic        valid_f, ready_f;
    logic [31:0] instr_d, pc_d, pc_plus_4_d;
    logic        valid_d, ready_d, flush_d;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t      exp_q[$];
    logic [31:0] exp_empty_pc  = '0;
    logic [31:0] exp_empty_pc4 = '0;

    pipe_fetch_skid dut (
        .clk         (clk),
        .reset       (reset),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pc_plus_4_f (pc_plus_4_f),
        .valid_f     (valid_f),
        .ready_f     (ready_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus_4_d (pc_plus_4_d),
        .valid_d     (valid_d),
        .ready_d     (ready_d),
        .flush_d     (flush_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0093;
    endfunction

    // Set all inputs for the next edge (blocking, from the driver only).
    task automatic drive(input logic v, input logic [31:0] pc, input logic rd, input logic fl);
        valid_f     = v;
        pc_f        = pc;
        pc_plus_4_f = pc + 32'd4;
        instr_f     = mk_instr(pc);
        ready_d     = rd;
        flush_d     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard: the model predicts occupancy and the head entry.
    // It then applies the transfer that the upcoming posedge will perform.
    always @(negedge clk) begin
        entry_t head;
        logic   in_f, out_f;
        int     cnt;
        cnt = exp_q.size();
        check("ready_f", {31'd0, ready_f}, {31'd0, cnt != 2});
        check("valid_d", {31'd0, valid_d}, {31'd0, cnt != 0});
        if (cnt != 0) begin
            head = exp_q[0];
            check("instr_d", instr_d, head.instr);
            check("pc_d", pc_d, head.pc);
            check("pc_plus_4_d", pc_plus_4_d, head.pc4);
        end else begin
            check("instr_d_nop", instr_d, NOP);
            check("pc_d_empty", pc_d, exp_empty_pc);
            check("pc4_d_empty", pc_plus_4_d, exp_empty_pc4);
        end
        if (reset || flush_d) begin
            exp_q.delete();
            exp_empty_pc  = '0;
            exp_empty_pc4 = '0;
        end else begin
            in_f  = valid_f && (cnt != 2);
            out_f = ready_d && (cnt != 0);
            if (out_f) begin
                head = exp_q.pop_front();
                if (!in_f && cnt == 1) begin
                    exp_empty_pc  = head.pc;
                    exp_empty_pc4 = head.pc4;
                end
            end
            if (in_f) exp_q.push_back('{instr: mk_instr(pc_f), pc: pc_f, pc4: pc_f + 32'd4});
        end
    end

    // Watchdog keeps the run bounded.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seq;
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        check("rst_valid_d", {31'd0, valid_d}, 32'd0);
        check("rst_ready_f", {31'd0, ready_f}, 32'd1);
        check("rst_instr_d", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'd0);
        reset = 1'b0;

        // 1: streaming at full rate. Each pc appears one cycle later.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            step();
            check("stream_pc_d", pc_d, 32'(i * 4));
            check("stream_ready_f", {31'd0, ready_f}, 32'd1);
        end
        // pc_plus_4 wrap is carried unchanged.
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step();
        check("wrap_pc4_d", pc_plus_4_d, 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        step();
        step();

        // 2: stall into FULL, then drain in order.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        step();
        check("stall_ready_f", {31'd0, ready_f}, 32'd0);
        check("stall_pc_d", pc_d, 32'h100);
        drive(1'b1, 32'h108, 1'b0, 1'b0);
        step();
        check("stall_hold_pc_d", pc_d, 32'h100);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        step();
        check("drain_pc_d", pc_d, 32'h104);
        check("drain_ready_f", {31'd0, ready_f}, 32'd1);
        step();
        check("drained_valid_d", {31'd0, valid_d}, 32'd0);
        check("drained_instr_d", instr_d, NOP);
        check("drained_pc_hold", pc_d, 32'h104);

        // 3: flush while FULL.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        step();
        check("flush_valid_d", {31'd0, valid_d}, 32'd0);
        check("flush_instr_d", instr_d, NOP);
        check("flush_pc_d", pc_d, 32'd0);
        check("flush_ready_f", {31'd0, ready_f}, 32'd1);

        // 4: flush with same-cycle in_fire drops that entry.
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        step();
        check("flush_in_valid_d", {31'd0, valid_d}, 32'd0);
        drive(1'b1, 32'h204, 1'b1, 1'b0);
        step();
        check("after_flush_pc_d", pc_d, 32'h204);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        step();

        // 5: synchronous reset while FULL.
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        check("rst_full_valid_d", {31'd0, valid_d}, 32'd0);
        check("rst_full_ready_f", {31'd0, ready_f}, 32'd1);
        check("rst_full_instr_d", instr_d, NOP);
        check("rst_full_pc_d", pc_d, 32'd0);
        reset = 1'b0;

        // 6: random traffic checked by the monitor.
        seq = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, seq, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0);
            seq += 32'd4;
            step();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        step();
        step();
        check("final_empty", {31'd0, valid_d}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
